// File: rtl/seq_divider_if.sv
// Request/result bundle for the sequential restoring divider.
interface seq_divider_if #(parameter int WIDTH = 8);
  logic             start;
  logic             sgn;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] r;

  modport master (output start, sgn, dividend, divisor,
                  input  busy, done, q, r);
  modport slave  (input  start, sgn, dividend, divisor,
                  output busy, done, q, r);
endinterface

// File: rtl/seq_divider.sv
// Radix-2 restoring divider, one quotient bit per clock, trial subtract on a cla4 chain.
// Define DIV_SIGNED_EN to add two's-complement operation selected by sgn.
module cla4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  logic [3:0] p;
  logic [3:0] g;
  logic [4:0] c;

  assign p = a ^ b;
  assign g = a & b;
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cin);
  assign sum  = p ^ c[3:0];
  assign cout = c[4];
endmodule

module seq_divider #(parameter int WIDTH = 8) (
  input logic          clk,
  input logic          rst,
  seq_divider_if.slave bus
);
  localparam int CW     = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam int SLICES = WIDTH / 4;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvs;

  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;
  logic [WIDTH-1:0] rem_sh;
  logic [WIDTH-1:0] dvs_inv;
  logic [WIDTH-1:0] trial;
  logic [SLICES:0]  carry;
  logic             no_borrow;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

`ifdef DIV_SIGNED_EN
  logic dvd_neg;
  logic dvs_neg;
  logic neg_q;
  logic neg_r;

  assign dvd_neg = bus.sgn & bus.dividend[WIDTH-1];
  assign dvs_neg = bus.sgn & bus.divisor[WIDTH-1];
  assign dvd_mag = dvd_neg ? (~bus.dividend + 1'b1) : bus.dividend;
  assign dvs_mag = dvs_neg ? (~bus.divisor + 1'b1) : bus.divisor;
  assign q_fix   = neg_q ? (~quo_next + 1'b1) : quo_next;
  assign r_fix   = neg_r ? (~rem_next + 1'b1) : rem_next;
`else
  assign dvd_mag = bus.dividend;
  assign dvs_mag = bus.divisor;
  assign q_fix   = quo_next;
  assign r_fix   = rem_next;
`endif

  assign rem_sh  = {rem[WIDTH-2:0], quo[WIDTH-1]};
  assign dvs_inv = ~dvs;
  assign carry[0] = 1'b1;

  for (genvar i = 0; i < SLICES; i++) begin : g_sub
    cla4 u_cla4 (
      .a    (rem_sh[4*i +: 4]),
      .b    (dvs_inv[4*i +: 4]),
      .cin  (carry[i]),
      .sum  (trial[4*i +: 4]),
      .cout (carry[i+1])
    );
  end

  // A bit shifted out of the top of rem means the shifted value exceeds any divisor.
  assign no_borrow = carry[SLICES] | rem[WIDTH-1];
  assign rem_next  = no_borrow ? trial : rem_sh;
  assign quo_next  = {quo[WIDTH-2:0], no_borrow};

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      rem      <= '0;
      quo      <= '0;
      dvs      <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.q    <= '0;
      bus.r    <= '0;
`ifdef DIV_SIGNED_EN
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
`endif
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            if (bus.divisor == '0) begin
              bus.q    <= '1;
              bus.r    <= bus.dividend;
              bus.done <= 1'b1;
              bus.busy <= 1'b0;
              state    <= DONE;
            end else begin
              rem      <= '0;
              quo      <= dvd_mag;
              dvs      <= dvs_mag;
              cnt      <= CW'(WIDTH - 1);
              bus.busy <= 1'b1;
              state    <= CALC;
`ifdef DIV_SIGNED_EN
              neg_q    <= dvd_neg ^ dvs_neg;
              neg_r    <= dvd_neg;
`endif
            end
          end else begin
            state <= IDLE;
          end
        end
        CALC: begin
          rem <= rem_next;
          quo <= quo_next;
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
            bus.q    <= q_fix;
            bus.r    <= r_fix;
            bus.done <= 1'b1;
            bus.busy <= 1'b0;
            state    <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_divider.sv
// Randomized self-checking bench for seq_divider against an arithmetic reference model.
// Define DIV_SIGNED_EN to also exercise signed division.
module tb_seq_divider;
  localparam int W = 8;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  seq_divider_if #(.WIDTH(W)) bus ();

  seq_divider #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Quotient/remainder straight from the arithmetic definition.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                       output logic [W-1:0] eq, output logic [W-1:0] er);
    int sa;
    int sb;
    int sq;
    int sr;
    if (b == 0) begin
      eq = '1;
      er = a;
    end else begin
`ifdef DIV_SIGNED_EN
      if (s) begin
        sa = int'($signed(a));
        sb = int'($signed(b));
      end else begin
        sa = int'(a);
        sb = int'(b);
      end
`else
      sa = int'(a);
      sb = int'(b);
`endif
      sq = sa / sb;
      sr = sa % sb;
      eq = sq[W-1:0];
      er = sr[W-1:0];
    end
  endtask

  // Called at a negedge; the following posedge samples the request.
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    bus.sgn      = s;
    @(posedge clk);
  endtask

  task automatic runOp(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic s, input int glitch);
    logic [W-1:0] eq;
    logic [W-1:0] er;
    int lat;
    int bc;
    lat = 0;
    bc  = 0;
    model(a, b, s, eq, er);
    applyStimulus(a, b, s);
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (cyc == 1) bus.start = 1'b0;
      if (glitch != 0 && cyc == glitch) begin
        bus.start    = 1'b1;
        bus.dividend = 8'd9;
        bus.divisor  = 8'd3;
      end
      if (glitch != 0 && cyc == glitch + 1) bus.start = 1'b0;
      if (bus.busy) bc++;
      if (bus.done) begin
        lat = cyc;
        break;
      end
    end
    checkOutput({tag, " latency"}, 32'(lat), (b == 0) ? 32'd1 : 32'(W + 1));
    checkOutput({tag, " busy cycles"}, 32'(bc), (b == 0) ? 32'd0 : 32'(W));
    checkOutput({tag, " q"}, 32'(bus.q), 32'(eq));
    checkOutput({tag, " r"}, 32'(bus.r), 32'(er));
  endtask

  task automatic checkQuiet(input string tag, input int n);
    int dc;
    dc = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (bus.done) dc++;
    end
    checkOutput({tag, " extra done"}, 32'(dc), 32'd0);
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rs;
    total        = 0;
    bad          = 0;
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.sgn      = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset busy", 32'(bus.busy), 32'd0);
    checkOutput("reset done", 32'(bus.done), 32'd0);
    checkOutput("reset q", 32'(bus.q), 32'd0);
    checkOutput("reset r", 32'(bus.r), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    runOp("100/7", 8'd100, 8'd7, 1'b0, 0);
    checkQuiet("100/7", 3);

    runOp("255/1", 8'd255, 8'd1, 1'b0, 0);
    runOp("3/200 b2b", 8'd3, 8'd200, 1'b0, 0);
    checkQuiet("3/200", 3);

    runOp("5/0", 8'd5, 8'd0, 1'b0, 0);
    checkQuiet("5/0", 3);

    runOp("100/7 glitch", 8'd100, 8'd7, 1'b0, 3);
    checkQuiet("glitch", 12);

    // Abort mid-calculation: rst is driven during cycle 4.
    applyStimulus(8'd100, 8'd7, 1'b0);
    for (int cyc = 1; cyc <= 4; cyc++) begin
      @(negedge clk);
      if (cyc == 1) bus.start = 1'b0;
      if (cyc == 4) rst = 1'b1;
    end
    @(negedge clk);
    checkOutput("abort busy", 32'(bus.busy), 32'd0);
    checkOutput("abort done", 32'(bus.done), 32'd0);
    checkOutput("abort q", 32'(bus.q), 32'd0);
    checkOutput("abort r", 32'(bus.r), 32'd0);
    rst = 1'b0;
    checkQuiet("abort", 15);

`ifdef DIV_SIGNED_EN
    runOp("-7/2", 8'hF9, 8'd2, 1'b1, 0);
    runOp("-128/-1", 8'h80, 8'hFF, 1'b1, 0);
    runOp("7/-2", 8'd7, 8'hFE, 1'b1, 0);
`endif

    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom);
      rb = ($urandom_range(0, 9) == 0) ? '0 : W'($urandom);
`ifdef DIV_SIGNED_EN
      rs = 1'($urandom);
`else
      rs = 1'b0;
`endif
      runOp($sformatf("rand%0d %0h/%0h s%0d", i, ra, rb, rs), ra, rb, rs, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/seq_divider.md
# seq_divider

Sequential radix-2 restoring divider. It computes quotient and remainder of a WIDTH-bit dividend by a WIDTH-bit divisor, one quotient bit per clock. It is the inverse datapath to the Booth multiplier and sits beside it in the arithmetic unit. Each trial subtraction is a WIDTH-bit add of the partial remainder and the inverted divisor with carry-in 1, built from chained `cla4` carry-lookahead slices. The carry-out is the "no borrow" flag.

## Interface
- `WIDTH`, 8: operand width; must be a multiple of 4 and ≥ 4.
- `clk`  in  1  clock, rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request; sampled only when the block is accepting (IDLE or DONE).
- `sgn`  in  1  signed operation; sampled with `start`; used only when `DIV_SIGNED_EN` is defined.
- `dividend`  in  WIDTH  numerator; sampled with `start`.
- `divisor`  in  WIDTH  denominator; sampled with `start`.
- `busy`  out  1  high while in CALC.
- `done`  out  1  one-cycle pulse; `q` and `r` are valid.
- `q`  out  WIDTH  quotient; held until the next accepted `start`.
- `r`  out  WIDTH  remainder; held until the next accepted `start`.

## Operation
- FSM states: IDLE, CALC, DONE.
- IDLE + `start`:
  - Latch operands.
  - If `divisor` = 0, go to DONE with `q` = all ones and `r` = `dividend`.
  - Otherwise load partial remainder 0, quotient register = |dividend|, counter = WIDTH−1, go to CALC.
- CALC, per cycle:
  - Shift {rem, quo} left by 1.
  - Trial = rem − |divisor|, via `cla4` chain.
  - If carry-out = 1: rem = trial and quo[0] = 1; else quo[0] = 0.
  - Counter decrements. After the iteration at counter = 0, go to DONE.
- DONE:
  - `done` = 1 for exactly one cycle. `q`/`r` registered outputs are updated on entry.
  - Next state is IDLE, or a new load if `start` = 1; back-to-back requests are accepted in DONE.
- `start` in CALC is ignored; no queuing.
- All arithmetic is unsigned WIDTH-bit.
- Results satisfy dividend = q·divisor + r, with r < divisor.

## Timing
- Reset values: `busy` = 0, `done` = 0, `q` = 0, `r` = 0; state IDLE, counter 0.
- `rst` mid-CALC aborts the operation. On the following cycle all outputs are at reset values and no `done` is issued.
- `rst` has priority over `start` in the same cycle.
- Latency, with `start` sampled at edge 0:
  - Nonzero divisor: `busy` is high in cycles 1..WIDTH; `done` is high in cycle WIDTH+1.
  - Zero divisor: `done` is high in cycle 1; `busy` never asserts.
- Throughput: one operation per WIDTH+1 cycles when `start` is held in DONE.
- `q`/`r` change only on entry to DONE or on reset.

## Configuration
- `DIV_SIGNED_EN` defined:
  - When `sgn` = 1, operands are two's complement.
  - Magnitudes are divided. The quotient is negated if the operand signs differ. The remainder takes the dividend's sign (truncation toward zero).
  - Overflow case: −2^(WIDTH−1) / −1 gives `q` = 100…0 and `r` = 0, with no wrap fault.
  - Sign fix-up is applied in the same cycle as DONE entry; latency is unchanged.
- `DIV_SIGNED_EN` undefined: `sgn` is ignored, all operations are unsigned, and no sign logic is synthesized.

## Test plan
- WIDTH=8, 100/7 → `busy` high cycles 1–8; `done` in cycle 9; `q` = 14, `r` = 2.
- 255/1 → `q` = 255, `r` = 0. Then 3/200 issued in the DONE cycle → accepted back-to-back; `q` = 0, `r` = 3 after 9 further cycles.
- 5/0 → `done` in cycle 1, `busy` never high, `q` = 0xFF, `r` = 5.
- `start` with 9/3 pulsed during CALC of 100/7 → ignored; result is still 14/2, and exactly one `done` pulse.
- `rst` asserted in cycle 4 of 100/7 → cycle 5 shows `busy` = 0, `done` = 0, `q` = `r` = 0, and no later `done`.
- With `DIV_SIGNED_EN`, `sgn` = 1:
  - −7/2 → `q` = 0xFD (−3), `r` = 0xFF (−1).
  - −128/−1 → `q` = 0x80, `r` = 0.
  - 7/−2 → `q` = 0xFD, `r` = 1.
